mem_access_unit: RTL and testbench

//  Parametrised load/store stage between the ALU memOp output and the data bus.

---
 rtl/mem_access_unit_if.sv | 42 ++++
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Load/store stage bundle: memOp from the ALU, request/response data bus, and regOp writeback.
interface mem_access_unit_if #(
  parameter int XLEN     = 32,
  parameter int REGSEL_W = 5
);
  logic                  memOpVld;
  logic                  memOpRdy;
  logic                  memRead;
  logic                  memWrite;
  logic [XLEN-1:0]       memAddr;
  logic [XLEN-1:0]       memData;
  logic [2:0]            memOpType;
  logic [REGSEL_W-1:0]   memRdAddr;
  logic                  busReqVld;
  logic                  busReqRdy;
  logic                  busReqWe;
  logic [XLEN-1:0]       busReqAddr;
  logic [XLEN-1:0]       busReqWdata;
  logic [XLEN/8-1:0]     busReqBe;
  logic                  busRspVld;
  logic [XLEN-1:0]       busRspData;
  logic                  regDv;
  logic [REGSEL_W-1:0]   regAddr;
  logic [XLEN-1:0]       regData;
  logic                  fault;
  logic [XLEN-1:0]       faultAddr;
  logic [2:0]            pendCnt;

  modport slave (
    input  memOpVld, memRead, memWrite, memAddr, memData, memOpType, memRdAddr,
    input  busReqRdy, busRspVld, busRspData,
    output memOpRdy, busReqVld, busReqWe, busReqAddr, busReqWdata, busReqBe,
    output regDv, regAddr, regData, fault, faultAddr, pendCnt
  );

  modport master (
    output memOpVld, memRead, memWrite, memAddr, memData, memOpType, memRdAddr,
    output busReqRdy, busRspVld, busRspData,
    input  memOpRdy, busReqVld, busReqWe, busReqAddr, busReqWdata, busReqBe,
    input  regDv, regAddr, regData, fault, faultAddr, pendCnt
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store stage: issues byte-enabled bus requests, tracks in-order outstanding loads,
// and extends returned data into a register writeback. Bad accesses pulse fault instead.
module mem_access_unit #(
  parameter int XLEN        = 32,
  parameter int REGSEL_W    = 5,
  parameter int OUTST_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  mem_access_unit_if.slave bus
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int SEL_W = $clog2(XLEN);

  typedef struct packed {
    logic [REGSEL_W-1:0] rd;
    logic [2:0]          t;
    logic [OFF_W-1:0]    off;
  } ld_t;

  logic                r_req_vld, r_we, r_dv, r_fault;
  logic [XLEN-1:0]     r_addr, r_wdata, r_rdata, r_faddr;
  logic [NB-1:0]       r_be;
  logic [REGSEL_W-1:0] r_raddr;
  logic [2:0]          r_pend;
  logic [1:0]          r_wptr, r_rptr;
  ld_t                 r_q [4];

  logic [OFF_W-1:0] w_off, w_smask;
  logic [3:0]       w_size, w_rsz;
  logic [15:0]      w_lane;
  logic [NB-1:0]    w_be;
  logic [XLEN-1:0]  w_wdata, w_shift, w_mask, w_ext;
  logic [6:0]       w_sidx;
  logic             w_illegal, w_mis, w_active, w_fault, w_issue, w_full;
  logic             w_accept, w_push, w_pop, w_sign;
  ld_t              w_head;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(OUTST_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_off     = bus.memAddr[OFF_W-1:0];
  assign w_size    = 4'd1 << bus.memOpType[1:0];
  assign w_smask   = OFF_W'(w_size - 4'd1);
  assign w_mis     = (w_off & w_smask) != '0;
  // Double-word and WU only exist on a 64-bit datapath; stores never take the unsigned types.
  assign w_illegal = (bus.memRead & bus.memWrite) | (bus.memOpType == 3'd7) |
                     (bus.memWrite & bus.memOpType[2]) |
                     ((XLEN == 32) && (bus.memOpType == 3'd3 || bus.memOpType == 3'd6));
  assign w_active  = bus.memRead | bus.memWrite;
  assign w_fault   = w_active & (w_illegal | w_mis);
  assign w_issue   = w_active & ~w_fault;
  assign w_full    = (r_pend == 3'(OUTST_DEPTH));
  assign bus.memOpRdy = (~r_req_vld | bus.busReqRdy) & ~(bus.memRead & w_full);
  assign w_accept  = bus.memOpVld & bus.memOpRdy;
  assign w_push    = w_accept & w_issue & bus.memRead;
  assign w_pop     = bus.busRspVld & (r_pend != 3'd0);
  assign w_lane    = (16'd1 << w_size) - 16'd1;
  assign w_be      = NB'(w_lane << w_off);

  always_comb begin
    logic [OFF_W-1:0] j;
    j       = '0;
    w_wdata = '0;
    for (int i = 0; i < NB; i++) begin
      j = OFF_W'(i) & w_smask;
      w_wdata[i*8 +: 8] = bus.memData[{j, 3'b000} +: 8];
    end
  end

  assign w_head  = r_q[r_rptr];
  assign w_rsz   = 4'd1 << w_head.t[1:0];
  assign w_shift = bus.busRspData >> {w_head.off, 3'b000};
  assign w_sidx  = {w_rsz, 3'b000} - 7'd1;
  assign w_sign  = w_shift[w_sidx[SEL_W-1:0]];

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NB; i++)
      w_mask[i*8 +: 8] = (i < int'(w_rsz)) ? 8'hFF : 8'h00;
    w_ext = (w_shift & w_mask) | ((~w_head.t[2] & w_sign) ? ~w_mask : '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_req_vld <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_dv      <= 1'b0;
      r_raddr   <= '0;
      r_rdata   <= '0;
      r_fault   <= 1'b0;
      r_faddr   <= '0;
      r_pend    <= 3'd0;
      r_wptr    <= 2'd0;
      r_rptr    <= 2'd0;
    end else begin
      r_fault <= w_accept & w_fault;
      if (w_accept & w_fault)
        r_faddr <= bus.memAddr;

      if (w_accept & w_issue) begin
        r_req_vld <= 1'b1;
        r_we      <= bus.memWrite;
        r_addr    <= bus.memAddr & ~XLEN'(NB - 1);
        r_be      <= w_be;
        r_wdata   <= bus.memWrite ? w_wdata : '0;
      end else if (bus.busReqRdy) begin
        r_req_vld <= 1'b0;
      end

      if (w_push) begin
        r_q[r_wptr] <= '{rd: bus.memRdAddr, t: bus.memOpType, off: w_off};
        r_wptr      <= ptr_inc(r_wptr);
      end
      if (w_pop)
        r_rptr <= ptr_inc(r_rptr);

      case ({w_push, w_pop})
        2'b10:   r_pend <= r_pend + 3'd1;
        2'b01:   r_pend <= r_pend - 3'd1;
        default: r_pend <= r_pend;
      endcase

      // Writes to x0 still retire the queue entry but produce no writeback.
      r_dv <= w_pop & (w_head.rd != '0);
      if (w_pop) begin
        r_raddr <= w_head.rd;
        r_rdata <= w_ext;
      end
    end
  end

  assign bus.busReqVld   = r_req_vld;
  assign bus.busReqWe    = r_we;
  assign bus.busReqAddr  = r_addr;
  assign bus.busReqWdata = r_wdata;
  assign bus.busReqBe    = r_be;
  assign bus.regDv       = r_dv;
  assign bus.regAddr     = r_raddr;
  assign bus.regData     = r_rdata;
  assign bus.fault       = r_fault;
  assign bus.faultAddr   = r_faddr;
  assign bus.pendCnt     = r_pend;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit at XLEN=32 and XLEN=64.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.XLEN(32), .REGSEL_W(5)) b32();
  mem_access_unit_if #(.XLEN(64), .REGSEL_W(5)) b64();

  mem_access_unit #(.XLEN(32), .REGSEL_W(5), .OUTST_DEPTH(2)) u32 (.clk(clk), .rstn(rstn), .bus(b32));
  mem_access_unit #(.XLEN(64), .REGSEL_W(5), .OUTST_DEPTH(2)) u64 (.clk(clk), .rstn(rstn), .bus(b64));

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (32-bit datapath) ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  t;
    logic [31:0] a;
  } ld_t;

  function automatic int msize(input logic [2:0] t);
    case (t)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      default:    return 8;
    endcase
  endfunction

  function automatic bit m_bad(input bit r, input bit w, input logic [2:0] t, input logic [31:0] a);
    if (r && w) return 1;
    if (t == 3'd7 || t == 3'd3 || t == 3'd6) return 1;
    if (w && t > 3'd3) return 1;
    return (a % msize(t)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] a);
    int v;
    v = ((1 << msize(t)) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] d);
    logic [31:0] r;
    int sz;
    sz = msize(t);
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = d[(i % sz)*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] t, input int off, input logic [31:0] rsp);
    logic [63:0] v, mask;
    int sz;
    sz   = msize(t);
    v    = {32'd0, rsp} >> (off * 8);
    mask = (64'd1 << (sz * 8)) - 64'd1;
    v    = v & mask;
    if (t < 3'd4 && v[sz*8-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  ld_t         q[$];
  bit          exp_rv, exp_we, exp_f, exp_dv;
  logic [31:0] exp_addr, exp_wd, exp_fa, exp_rdat;
  logic [3:0]  exp_be;
  logic [4:0]  exp_ra;

  initial begin
    bit  mrdy;
    ld_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        q.delete();
        exp_rv = 0; exp_f = 0; exp_dv = 0; exp_fa = '0;
      end else begin
        chk("pendCnt", b32.pendCnt, q.size());
        mrdy = (!exp_rv || b32.busReqRdy) && !(b32.memRead && q.size() == 2);
        chk("memOpRdy", b32.memOpRdy, mrdy);
        chk("busReqVld", b32.busReqVld, exp_rv);
        if (exp_rv) begin
          chk("busReqAddr", b32.busReqAddr, exp_addr);
          chk("busReqWe", b32.busReqWe, exp_we);
          chk("busReqBe", b32.busReqBe, exp_be);
          chk("busReqWdata", b32.busReqWdata, exp_wd);
        end
        chk("fault", b32.fault, exp_f);
        chk("faultAddr", b32.faultAddr, exp_fa);
        chk("regDv", b32.regDv, exp_dv);
        if (exp_dv) begin
          chk("regAddr", b32.regAddr, exp_ra);
          chk("regData", b32.regData, exp_rdat);
        end
        // events at the coming rising edge
        if (exp_rv && b32.busReqRdy) exp_rv = 0;
        exp_dv = 0;
        if (b32.busRspVld && q.size() > 0) begin
          e = q.pop_front();
          if (e.rd != 0) begin
            exp_dv   = 1;
            exp_ra   = e.rd;
            exp_rdat = m_load(e.t, int'(e.a % 4), b32.busRspData);
          end
        end
        exp_f = 0;
        if (b32.memOpVld && mrdy && (b32.memRead || b32.memWrite)) begin
          if (m_bad(b32.memRead, b32.memWrite, b32.memOpType, b32.memAddr)) begin
            exp_f  = 1;
            exp_fa = b32.memAddr;
          end else begin
            exp_rv   = 1;
            exp_we   = b32.memWrite;
            exp_addr = b32.memAddr & 32'hFFFF_FFFC;
            exp_be   = m_be(b32.memOpType, b32.memAddr);
            exp_wd   = b32.memWrite ? m_wdata(b32.memOpType, b32.memData) : 32'd0;
            if (b32.memRead) q.push_back('{rd: b32.memRdAddr, t: b32.memOpType, a: b32.memAddr});
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle32();
    b32.memOpVld = 0; b32.memRead = 0; b32.memWrite = 0; b32.memAddr = '0;
    b32.memData = '0; b32.memOpType = '0; b32.memRdAddr = '0;
    b32.busReqRdy = 1; b32.busRspVld = 0; b32.busRspData = '0;
  endtask

  task automatic idle64();
    b64.memOpVld = 0; b64.memRead = 0; b64.memWrite = 0; b64.memAddr = '0;
    b64.memData = '0; b64.memOpType = '0; b64.memRdAddr = '0;
    b64.busReqRdy = 1; b64.busRspVld = 0; b64.busRspData = '0;
  endtask

  task automatic op32(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] t, input logic [4:0] rd);
    int n;
    b32.memOpVld = 1; b32.memRead = r; b32.memWrite = w; b32.memAddr = a;
    b32.memData = d; b32.memOpType = t; b32.memRdAddr = rd;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (b32.memOpRdy) break;
    end
    if (n == 50) chk("op32_accept_timeout", 0, 1);
    @(posedge clk); #1;
    b32.memOpVld = 0; b32.memRead = 0; b32.memWrite = 0;
  endtask

  task automatic op64(input bit r, input bit w, input logic [63:0] a, input logic [63:0] d,
                      input logic [2:0] t, input logic [4:0] rd);
    int n;
    b64.memOpVld = 1; b64.memRead = r; b64.memWrite = w; b64.memAddr = a;
    b64.memData = d; b64.memOpType = t; b64.memRdAddr = rd;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (b64.memOpRdy) break;
    end
    if (n == 50) chk("op64_accept_timeout", 0, 1);
    @(posedge clk); #1;
    b64.memOpVld = 0; b64.memRead = 0; b64.memWrite = 0;
  endtask

  task automatic rsp32(input logic [31:0] d);
    b32.busRspVld = 1; b32.busRspData = d;
    @(posedge clk); #1;
    b32.busRspVld = 0;
  endtask

  task automatic rsp64(input logic [63:0] d);
    b64.busRspVld = 1; b64.busRspData = d;
    @(posedge clk); #1;
    b64.busRspVld = 0;
  endtask

  initial begin
    idle32(); idle64();
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    @(posedge clk); #1;

    // model anchors
    chk("model_lb", m_load(3'd0, 3, 32'h80FF_FFFF), 32'hFFFF_FF80);
    chk("model_be_sh", m_be(3'd1, 32'h102), 4'hC);
    chk("model_wd_sh", m_wdata(3'd1, 32'h1234), 32'h1234_1234);
    chk("model_mis_lh", m_bad(1, 0, 3'd1, 32'h101), 1);

    // reset state
    chk("rst_busReqVld", b32.busReqVld, 0);
    chk("rst_regDv", b32.regDv, 0);
    chk("rst_fault", b32.fault, 0);
    chk("rst_pendCnt", b32.pendCnt, 0);
    chk("rst_faultAddr", b32.faultAddr, 0);
    chk("rst_busReqAddr", b32.busReqAddr, 0);
    chk("rst_memOpRdy", b32.memOpRdy, 1);

    // LW
    op32(1, 0, 32'h100, 0, 3'd2, 5'd5);
    chk("lw_vld", b32.busReqVld, 1);
    chk("lw_addr", b32.busReqAddr, 32'h100);
    chk("lw_be", b32.busReqBe, 4'hF);
    chk("lw_we", b32.busReqWe, 0);
    chk("lw_wdata", b32.busReqWdata, 0);
    chk("lw_pend", b32.pendCnt, 1);
    rsp32(32'hDEAD_BEEF);
    chk("lw_dv", b32.regDv, 1);
    chk("lw_rd", b32.regAddr, 5);
    chk("lw_data", b32.regData, 32'hDEAD_BEEF);
    chk("lw_pend0", b32.pendCnt, 0);
    @(posedge clk); #1;
    chk("lw_dv_pulse", b32.regDv, 0);

    // LB / LBU at byte 3
    op32(1, 0, 32'h103, 0, 3'd0, 5'd6);
    chk("lb_be", b32.busReqBe, 4'h8);
    rsp32(32'h80FF_FFFF);
    chk("lb_data", b32.regData, 32'hFFFF_FF80);
    op32(1, 0, 32'h103, 0, 3'd4, 5'd6);
    rsp32(32'h80FF_FFFF);
    chk("lbu_data", b32.regData, 32'h0000_0080);

    // SH then misaligned LH
    op32(0, 1, 32'h102, 32'hABCD_1234, 3'd1, 5'd0);
    chk("sh_be", b32.busReqBe, 4'hC);
    chk("sh_wdata", b32.busReqWdata, 32'h1234_1234);
    chk("sh_we", b32.busReqWe, 1);
    chk("sh_addr", b32.busReqAddr, 32'h100);
    op32(1, 0, 32'h101, 0, 3'd1, 5'd7);
    chk("lh_fault", b32.fault, 1);
    chk("lh_faddr", b32.faultAddr, 32'h101);
    chk("lh_novld", b32.busReqVld, 0);
    chk("lh_nopend", b32.pendCnt, 0);
    @(posedge clk); #1;
    chk("lh_fault_pulse", b32.fault, 0);
    chk("lh_faddr_hold", b32.faultAddr, 32'h101);

    // depth stall
    b32.busRspVld = 0;
    op32(1, 0, 32'h200, 0, 3'd2, 5'd1);
    op32(1, 0, 32'h204, 0, 3'd2, 5'd2);
    b32.memOpVld = 1; b32.memRead = 1; b32.memAddr = 32'h208; b32.memOpType = 3'd2; b32.memRdAddr = 5'd3;
    @(negedge clk);
    chk("full_rdy", b32.memOpRdy, 0);
    chk("full_pend", b32.pendCnt, 2);
    @(posedge clk); #1;
    b32.busRspVld = 1; b32.busRspData = 32'h11;
    @(negedge clk);
    chk("full_nobypass", b32.memOpRdy, 0);
    @(posedge clk); #1;
    b32.busRspVld = 0;
    chk("full_rsp1", b32.regData, 32'h11);
    chk("full_rsp1_rd", b32.regAddr, 1);
    @(negedge clk);
    chk("full_rdy_after", b32.memOpRdy, 1);
    chk("full_pend1", b32.pendCnt, 1);
    @(posedge clk); #1;
    b32.memOpVld = 0; b32.memRead = 0;
    chk("third_pend", b32.pendCnt, 2);
    chk("third_addr", b32.busReqAddr, 32'h208);
    rsp32(32'h22);
    chk("rsp2_rd", b32.regAddr, 2);
    rsp32(32'h33);
    chk("rsp3_rd", b32.regAddr, 3);
    chk("rsp3_data", b32.regData, 32'h33);
    chk("drain_pend", b32.pendCnt, 0);

    // stalled store and async reset
    @(posedge clk); #1;
    b32.busReqRdy = 0;
    op32(0, 1, 32'h300, 32'hCAFE_F00D, 3'd2, 5'd0);
    b32.memOpVld = 1; b32.memWrite = 1; b32.memAddr = 32'h304; b32.memOpType = 3'd2;
    repeat (5) begin
      @(negedge clk);
      chk("stall_vld", b32.busReqVld, 1);
      chk("stall_addr", b32.busReqAddr, 32'h300);
      chk("stall_wdata", b32.busReqWdata, 32'hCAFE_F00D);
      chk("stall_be", b32.busReqBe, 4'hF);
      chk("stall_rdy", b32.memOpRdy, 0);
    end
    @(posedge clk); #2;
    rstn = 0;
    #1;
    chk("async_rst_vld", b32.busReqVld, 0);
    b32.memOpVld = 0; b32.memWrite = 0; b32.busReqRdy = 1;
    @(negedge clk);
    rstn = 1;
    @(posedge clk); #1;

    // load abandoned by reset; late response dropped
    op32(1, 0, 32'h400, 0, 3'd2, 5'd4);
    chk("abandon_pend", b32.pendCnt, 1);
    #2 rstn = 0;
    #1 rstn = 1;
    b32.busRspVld = 1; b32.busRspData = 32'h5555_5555;
    @(posedge clk); #1;
    b32.busRspVld = 0;
    chk("drop_dv", b32.regDv, 0);
    chk("drop_pend", b32.pendCnt, 0);

    // 64-bit datapath
    op64(1, 0, 64'h4, 0, 3'd6, 5'd9);
    chk("lwu64_addr", b64.busReqAddr, 64'h0);
    chk("lwu64_be", b64.busReqBe, 8'hF0);
    rsp64(64'h8000_0001_0000_0000);
    chk("lwu64_dv", b64.regDv, 1);
    chk("lwu64_data", b64.regData, 64'h0000_0000_8000_0001);
    op64(1, 0, 64'h4, 0, 3'd3, 5'd9);
    chk("ld64_fault", b64.fault, 1);
    chk("ld64_faddr", b64.faultAddr, 64'h4);
    chk("ld64_novld", b64.busReqVld, 0);
    op64(0, 1, 64'h5, 64'h77AB, 3'd0, 5'd0);
    chk("sb64_be", b64.busReqBe, 8'h20);
    chk("sb64_wdata", b64.busReqWdata, 64'hABAB_ABAB_ABAB_ABAB);
    op64(0, 1, 64'h8, 64'h1122_3344_5566_7788, 3'd3, 5'd0);
    chk("sd64_be", b64.busReqBe, 8'hFF);
    chk("sd64_wdata", b64.busReqWdata, 64'h1122_3344_5566_7788);
    op64(1, 0, 64'h10, 0, 3'd2, 5'd0);
    chk("lwx0_pend", b64.pendCnt, 1);
    rsp64(64'hFFFF_FFFF_FFFF_FFFF);
    chk("lwx0_dv", b64.regDv, 0);
    chk("lwx0_pend0", b64.pendCnt, 0);

    // randomized run against the model
    @(posedge clk); #2;
    rstn = 0;
    #2 rstn = 1;
    @(posedge clk); #1;
    mon_en = 1;
    for (int c = 0; c < 4000; c++) begin
      int k;
      logic [2:0] t;
      logic [31:0] a;
      k = $urandom_range(0, 9);
      b32.memOpVld = ($urandom_range(0, 3) != 0);
      b32.memRead  = (k == 1) || (k >= 2 && k <= 5);
      b32.memWrite = (k == 1) || (k >= 6);
      t = 3'($urandom_range(0, 7));
      if (k >= 6 && $urandom_range(0, 3) != 0) t = 3'($urandom_range(0, 2));
      if (k >= 2 && k <= 5 && $urandom_range(0, 3) != 0) t = 3'($urandom_range(0, 5));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~32'(msize(t) - 1);
      b32.memOpType  = t;
      b32.memAddr    = a;
      b32.memData    = $urandom;
      b32.memRdAddr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      b32.busReqRdy  = ($urandom_range(0, 3) != 0);
      b32.busRspVld  = ($urandom_range(0, 2) == 0);
      b32.busRspData = $urandom;
      @(posedge clk); #1;
    end
    idle32();
    repeat (4) @(posedge clk);
    #1 mon_en = 0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
